counter_run_controller: RTL and testbench
=========================================

// Module: counter_run_controller
// PURPOSE
//   Sequencer for the 8-bit synchronous T-flip-flop counter. Generates the counter's
//   enable as single-cycle pulses from a programmable rate divider and drives its
//   active-low clear. Watches the counter value and stops or auto-reloads at a target.
//   Exposes start/pause/clear control. Sits between the board keys/switches and the counter.
// PARAMETERS
//   DIV_WIDTH  26          width of rate-divider down-counter
//   DIV_MAX    49_999_999  divider reload value; one step every DIV_MAX+1 clocks (1 Hz @ 50 MHz)
//   CNT_WIDTH  8           width of counter value and target
// PORTS
//   clock        in   1          rising-edge clock, sole clock domain
//   reset        in   1          synchronous, active-high reset
//   start_i      in   1          1-cycle pulse: run / resume
//   pause_i      in   1          1-cycle pulse: pause while running
//   clear_i      in   1          1-cycle pulse: clear counter, go idle
//   auto_reload  in   1          1 = clear and continue on match; 0 = stop on match
//   target       in   CNT_WIDTH  match value, sampled every cycle
//   count_in     in   CNT_WIDTH  counter value (counter Q)
//   cnt_enable   out  1          counter enable; registered, 1-cycle pulses
//   cnt_clear_b  out  1          counter clear, active-low; registered
//   busy         out  1          1 while state == RUN
//   done         out  1          1-cycle pulse on target match
//   state        out  2          IDLE=0, RUN=1, PAUSE=2, DONE=3
// BEHAVIOUR
//   - Clocking: all outputs are registered. Inputs are already synchronous single-cycle pulses.
//   - Reset: while reset=1, at each edge:
//     - state=IDLE, divider=DIV_MAX, cnt_enable=0, cnt_clear_b=0, done=0, busy=0.
//     - cnt_clear_b returns to 1 on the first edge with reset=0.
//     - Reset mid-run aborts immediately; the counter is held cleared.
//   - Priority per cycle: reset > clear_i > pause_i > start_i > match.
//   - Divider:
//     - Counts down only in RUN.
//     - At 0, reloads DIV_MAX and asserts cnt_enable for the next cycle (tick).
//     - Holds its value in PAUSE.
//     - Reloads DIV_MAX on clear_i, on start from IDLE/DONE, and on auto-reload match.
//   - Transitions:
//     - IDLE  --start_i--> RUN.
//     - RUN   --pause_i--> PAUSE.
//     - PAUSE --start_i--> RUN; resumes with the remaining divider phase.
//     - RUN   --match & !auto_reload--> DONE.
//     - RUN   --match & auto_reload--> RUN, with a clear.
//     - DONE  --start_i--> RUN; cnt_clear_b=0 for 1 cycle, so counting restarts from 0.
//     - Any state --clear_i--> IDLE; cnt_clear_b=0 for 1 cycle.
//     - start_i in RUN is ignored. pause_i outside RUN is ignored.
//   - Match detection:
//     - step_d = cnt_enable delayed 1 cycle.
//     - match = step_d & (count_in == target) & (state == RUN).
//     - Only post-step values are compared, so a cleared counter never re-matches spuriously.
//   - Latency:
//     - cnt_enable high in cycle T; the counter updates at the end of T.
//     - match is evaluated in T+1.
//     - done, the new state and cnt_clear_b=0 (auto-reload case) are visible in T+2.
//   - Clear and enable together: whenever cnt_clear_b=0, cnt_enable is forced 0.
//   - Boundaries:
//     - target=0 matches only after the 255->0 wrap, i.e. after 256 steps.
//     - Counter wrap-around is not a match unless target=0.
//     - pause_i arriving on the same cycle as a tick suppresses that tick.
//     - clear_i with start_i in the same cycle gives IDLE.
//     - A target change takes effect at the next step.
// TESTING  (bench uses DIV_MAX=3 -> 1 step per 4 clocks)
//   1. Reset, auto_reload=0, target=5, start_i -> cnt_enable every 4th cycle.
//      After the 5th pulse: done pulse at T+2, state=DONE, count_in holds 5, no more enables.
//   2. auto_reload=1, target=2, start_i -> count sequence 0,1,2,0,1,2.
//      done and 1-cycle cnt_clear_b=0 at each 2; state stays RUN.
//   3. RUN, pause_i 2 clocks after a step -> no enables during PAUSE.
//      On start_i, the next enable follows after the remaining 2 clocks, not 4.
//   4. RUN, clear_i and start_i in the same cycle -> state=IDLE, cnt_clear_b=0 for 1 cycle,
//      count_in=0, no enables.
//   5. target=0, auto_reload=0, run 256 steps -> no done at step 255.
//      done after the 255->0 step; state=DONE.
//   6. reset asserted mid-RUN for 1 cycle -> next edge: state=IDLE, cnt_clear_b=0,
//      cnt_enable=0, busy=0. Following cycle: cnt_clear_b=1.

Source files
------------

// File: rtl/counter_run_controller.sv
// Run sequencer for the 8-bit T-flip-flop counter: paced enable pulses, active-low clear,
// start/pause/clear control and target-match stop or auto-reload.
module counter_run_controller #(
    parameter int unsigned DIV_WIDTH = 26,
    parameter int unsigned DIV_MAX   = 49_999_999,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 pause_i,
    input  logic                 clear_i,
    input  logic                 auto_reload,
    input  logic [CNT_WIDTH-1:0] target,
    input  logic [CNT_WIDTH-1:0] count_in,
    output logic                 cnt_enable,
    output logic                 cnt_clear_b,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_RELOAD = DIV_WIDTH'(DIV_MAX);

    state_t               cur_q, cur_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 en_q, en_d;
    logic                 clr_b_q, clr_b_d;
    logic                 done_q, done_d;
    logic                 busy_q;
    logic                 step_d;
    logic                 match;

    // Only compare the value produced by the previous step, never a freshly cleared one.
    assign match = step_d && (count_in == target) && (cur_q == RUN);

    always_comb begin
        cur_d   = cur_q;
        div_d   = div_q;
        en_d    = 1'b0;
        clr_b_d = 1'b1;
        done_d  = 1'b0;

        if (clear_i) begin
            cur_d   = IDLE;
            div_d   = DIV_RELOAD;
            clr_b_d = 1'b0;
        end else if (pause_i && (cur_q == RUN)) begin
            cur_d = PAUSE;
        end else if (start_i && (cur_q != RUN)) begin
            cur_d = RUN;
            if (cur_q != PAUSE) begin
                div_d = DIV_RELOAD;
            end
            if (cur_q == DONE) begin
                clr_b_d = 1'b0;
            end
        end else if (cur_q == RUN) begin
            if (match) begin
                done_d = 1'b1;
                if (auto_reload) begin
                    div_d   = DIV_RELOAD;
                    clr_b_d = 1'b0;
                end else begin
                    cur_d = DONE;
                end
            end else if (div_q == '0) begin
                div_d = DIV_RELOAD;
                en_d  = 1'b1;
            end else begin
                div_d = div_q - DIV_WIDTH'(1);
            end
        end

        if (!clr_b_d) begin
            en_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_q   <= IDLE;
            div_q   <= DIV_RELOAD;
            en_q    <= 1'b0;
            clr_b_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            step_d  <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            div_q   <= div_d;
            en_q    <= en_d;
            clr_b_q <= clr_b_d;
            done_q  <= done_d;
            busy_q  <= (cur_d == RUN);
            step_d  <= en_q;
        end
    end

    assign cnt_enable  = en_q;
    assign cnt_clear_b = clr_b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state       = cur_q;

endmodule

// File: tb/tb_counter_run_controller.sv
// Directed bench for counter_run_controller with DIV_MAX=3; includes a behavioural
// model of the 8-bit counter so count_in follows cnt_enable/cnt_clear_b.
module tb_counter_run_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_i, pause_i, clear_i, auto_reload;
    logic [7:0] target;
    logic [7:0] count_in;
    logic       cnt_enable, cnt_clear_b, busy, done;
    logic [1:0] state;

    int checks = 0;
    int fails  = 0;
    int n      = 0;

    counter_run_controller #(
        .DIV_WIDTH(26),
        .DIV_MAX  (3),
        .CNT_WIDTH(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_i    (start_i),
        .pause_i    (pause_i),
        .clear_i    (clear_i),
        .auto_reload(auto_reload),
        .target     (target),
        .count_in   (count_in),
        .cnt_enable (cnt_enable),
        .cnt_clear_b(cnt_clear_b),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!cnt_clear_b)    count_in <= 8'd0;
        else if (cnt_enable) count_in <= count_in + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        n++;
    endtask

    // Sample after the edge that latches start_i is cycle 0.
    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        n = 0;
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; pause_i = 1'b0; clear_i = 1'b0;
        auto_reload = 1'b0; target = 8'd5;

        // 1: reset state, then stop on target 5
        repeat (3) step();
        check("rst_state", state, 0);
        check("rst_clr_b", cnt_clear_b, 0);
        check("rst_en", cnt_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        step();
        check("rst_rel_clr_b", cnt_clear_b, 1);
        check("rst_count", count_in, 0);
        pulse_start();
        check("t1_state_run", state, 1);
        check("t1_busy", busy, 1);
        for (int i = 1; i <= 30; i++) begin
            step();
            check("t1_en", cnt_enable, (n % 4 == 0) && (n <= 20));
            check("t1_done", done, n == 22);
            if (n == 22) check("t1_state_done", state, 3);
        end
        check("t1_state_end", state, 3);
        check("t1_count_end", count_in, 5);

        // 2: auto-reload at target 2 after restart from DONE
        auto_reload = 1'b1; target = 8'd2;
        pulse_start();
        check("t2_clr_b0", cnt_clear_b, 0);
        check("t2_state0", state, 1);
        for (int i = 1; i <= 21; i++) begin
            step();
            check("t2_en", cnt_enable, (n == 4) || (n == 8) || (n == 14) || (n == 18));
            check("t2_done", done, (n == 10) || (n == 20));
            check("t2_clr_b", cnt_clear_b, !((n == 10) || (n == 20)));
            check("t2_busy", busy, 1);
            if (n == 9)  check("t2_count2", count_in, 2);
            if (n == 11) check("t2_count0", count_in, 0);
        end

        // 3: pause two clocks after a step resumes with the remaining phase
        auto_reload = 1'b0; target = 8'd200;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("t3_clr_state", state, 0);
        check("t3_clr_b", cnt_clear_b, 0);
        step();
        check("t3_clr_b_rel", cnt_clear_b, 1);
        check("t3_count0", count_in, 0);
        pulse_start();
        for (int i = 1; i <= 6; i++) begin
            step();
            check("t3_en_pre", cnt_enable, n == 4);
        end
        pause_i = 1'b1;
        step();
        pause_i = 1'b0;
        check("t3_state_pause", state, 2);
        check("t3_busy_pause", busy, 0);
        while (n < 12) begin
            step();
            check("t3_en_pause", cnt_enable, 0);
            check("t3_state_hold", state, 2);
        end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("t3_state_resume", state, 1);
        check("t3_en_r0", cnt_enable, 0);
        step();
        check("t3_en_r1", cnt_enable, 0);
        step();
        check("t3_en_r2", cnt_enable, 1);
        step();
        check("t3_count2", count_in, 2);

        // 4: clear and start together while running
        clear_i = 1'b1; start_i = 1'b1;
        step();
        clear_i = 1'b0; start_i = 1'b0;
        check("t4_state", state, 0);
        check("t4_clr_b", cnt_clear_b, 0);
        check("t4_en", cnt_enable, 0);
        step();
        check("t4_clr_b_rel", cnt_clear_b, 1);
        check("t4_count", count_in, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("t4_en_idle", cnt_enable, 0);
            check("t4_state_idle", state, 0);
        end

        // 5: target 0 matches only after the wrap
        target = 8'd0;
        pulse_start();
        for (int i = 1; i <= 1030; i++) begin
            step();
            check("t5_done", done, n == 1026);
            if (n == 1022) check("t5_count255", count_in, 255);
            if (n == 1025) check("t5_state_run", state, 1);
            if (n == 1026) check("t5_state_done", state, 3);
        end

        // 6: reset mid-run, on the cycle a tick would otherwise appear
        target = 8'd200;
        pulse_start();
        repeat (7) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_state", state, 0);
        check("t6_clr_b", cnt_clear_b, 0);
        check("t6_en", cnt_enable, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        step();
        check("t6_clr_b_rel", cnt_clear_b, 1);

        // 7: pause on a tick cycle suppresses that tick
        pulse_start();
        repeat (3) step();
        pause_i = 1'b1;
        step();
        pause_i = 1'b0;
        check("t7_en_supp", cnt_enable, 0);
        check("t7_state_pause", state, 2);
        repeat (2) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("t7_en_r0", cnt_enable, 0);
        check("t7_state_run", state, 1);
        step();
        check("t7_en_r1", cnt_enable, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
